// File: rtl/spi_dpi_flash_if.sv
// App-SPI bus bundle between a controller and the SPI flash model, including the sideband pins.
interface spi_dpi_flash_if #(
    parameter int NDevices = 1,
    parameter int DataW    = 1,
    parameter int OOB_InW  = 2,
    parameter int OOB_OutW = 1
);
    logic                sck;
    logic [NDevices-1:0] cs;
    logic [DataW-1:0]    copi;
    logic                cipo;
    logic [OOB_InW-1:0]  oob_in;
    logic [OOB_OutW-1:0] oob_out;

    modport master (output sck, cs, copi, oob_in, input cipo, oob_out);
    modport slave  (input sck, cs, copi, oob_in, output cipo, oob_out);
endinterface

// File: rtl/spi_dpi_flash.sv
// SPI-NOR flash target (mode 0, MSB first) oversampling the bus with clk_i, backed by a byte memory.
module spi_dpi_flash #(
    parameter int          NDevices = 1,
    parameter int          DataW    = 1,
    parameter int          OOB_InW  = 2,
    parameter int          OOB_OutW = 1,
    parameter int          MemAddrW = 8,
    parameter logic [23:0] JedecId  = 24'hEF4016
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    spi_dpi_flash_if.slave bus
);
    localparam int                  MemSize  = 2 ** MemAddrW;
    localparam logic [MemAddrW-1:0] PageMask = MemAddrW'(255);
    localparam logic [7:0] OpRead    = 8'h03;
    localparam logic [7:0] OpProgram = 8'h02;
    localparam logic [7:0] OpJedec   = 8'h9F;
    localparam logic [7:0] OpStatus  = 8'h05;
    localparam logic [7:0] OpWren    = 8'h06;
    localparam logic [7:0] OpWrdi    = 8'h04;
    localparam logic [7:0] OpErase   = 8'hC7;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;

    if (DataW != 1 || NDevices < 1 || OOB_InW < 2 || OOB_OutW < 1 || MemAddrW < 1 || MemAddrW > 24)
    begin : g_badParams
        $error("spi_dpi_flash: unsupported parameter set");
    end

    state_t              r_state, w_stateNext;
    logic [1:0]          r_sckSync, r_csSync, r_copiSync, r_wpSync, r_holdSync;
    logic                r_sckPrev, r_csPrev;
    logic [7:0]          r_shiftIn, r_txShift, r_opcode;
    logic [2:0]          r_bitCnt;
    logic [3:0]          r_bitTotal;
    logic [1:0]          r_addrCnt, r_idIdx;
    logic [MemAddrW-1:0] r_addr;
    logic                r_cipo, r_wel, r_progAcc;
    logic [7:0]          r_mem [MemSize];
    // A byte reads as erased (FF) until programmed; erase just clears this map.
    logic [MemSize-1:0]  r_valid = '0;

    logic                w_csN, w_wpN, w_holdN, w_sckRise, w_sckFall, w_csRise, w_byteDone;
    logic                w_memWe, w_erase;
    logic [7:0]          w_byte, w_memRd, w_idByte, w_txByte;
    logic [MemAddrW-1:0] w_pageNext;

    assign w_csN      = r_csSync[1];
    assign w_wpN      = r_wpSync[1];
    assign w_holdN    = r_holdSync[1];
    assign w_sckRise  = r_sckSync[1] & ~r_sckPrev & w_holdN & ~w_csN;
    assign w_sckFall  = ~r_sckSync[1] & r_sckPrev & w_holdN & ~w_csN;
    assign w_csRise   = w_csN & ~r_csPrev;
    assign w_byte     = {r_shiftIn[6:0], r_copiSync[1]};
    assign w_byteDone = w_sckRise && (r_bitCnt == 3'd7);
    assign w_memRd    = r_valid[r_addr] ? r_mem[r_addr] : 8'hFF;
    assign w_memWe    = w_byteDone && (r_state == DATA) && (r_opcode == OpProgram);
    assign w_erase    = w_csRise && (r_opcode == OpErase) && r_wel && w_wpN;
    assign w_pageNext = (r_addr & ~PageMask) | ((r_addr + MemAddrW'(1)) & PageMask);

    assign bus.cipo    = r_cipo;
    assign bus.oob_out = OOB_OutW'(r_wel);

    always_comb begin
        w_idByte = JedecId[23:16];
        case (r_idIdx)
            2'd1:    w_idByte = JedecId[15:8];
            2'd2:    w_idByte = JedecId[7:0];
            default: ;
        endcase
        w_txByte = 8'h00;
        if (r_state == DATA) begin
            case (r_opcode)
                OpJedec:  w_txByte = w_idByte;
                OpStatus: w_txByte = {6'b0, r_wel, 1'b0};
                OpRead:   w_txByte = w_memRd;
                default:  ;
            endcase
        end
    end

    always_comb begin
        w_stateNext = r_state;
        if (w_csN) begin
            w_stateNext = IDLE;
        end else begin
            case (r_state)
                IDLE: w_stateNext = CMD;
                CMD: begin
                    if (w_byteDone) begin
                        case (w_byte)
                            OpRead:            w_stateNext = ADDR;
                            OpProgram:         w_stateNext = (r_wel && w_wpN) ? ADDR : IGNORE;
                            OpJedec, OpStatus: w_stateNext = DATA;
                            default:           w_stateNext = IGNORE;
                        endcase
                    end
                end
                ADDR: if (w_byteDone && r_addrCnt == 2'd2) w_stateNext = DATA;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_stateNext;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sckSync  <= '0;
            r_csSync   <= '1;
            r_copiSync <= '0;
            r_wpSync   <= '0;
            r_holdSync <= '0;
            r_sckPrev  <= 1'b0;
            r_csPrev   <= 1'b1;
            r_shiftIn  <= '0;
            r_txShift  <= '0;
            r_opcode   <= '0;
            r_bitCnt   <= '0;
            r_bitTotal <= '0;
            r_addrCnt  <= '0;
            r_idIdx    <= '0;
            r_addr     <= '0;
            r_cipo     <= 1'b0;
            r_wel      <= 1'b0;
            r_progAcc  <= 1'b0;
        end else begin
            r_sckSync  <= {r_sckSync[0], bus.sck};
            r_csSync   <= {r_csSync[0], bus.cs[0]};
            r_copiSync <= {r_copiSync[0], bus.copi[0]};
            r_wpSync   <= {r_wpSync[0], bus.oob_in[0]};
            r_holdSync <= {r_holdSync[0], bus.oob_in[1]};
            r_sckPrev  <= r_sckSync[1];
            r_csPrev   <= w_csN;
            if (w_csN) begin
                r_shiftIn  <= '0;
                r_txShift  <= '0;
                r_opcode   <= '0;
                r_bitCnt   <= '0;
                r_bitTotal <= '0;
                r_addrCnt  <= '0;
                r_idIdx    <= '0;
                r_cipo     <= 1'b0;
                r_progAcc  <= 1'b0;
            end else begin
                if (w_sckRise) begin
                    r_shiftIn <= w_byte;
                    r_bitCnt  <= r_bitCnt + 3'd1;
                    if (r_bitTotal != 4'hF) r_bitTotal <= r_bitTotal + 4'd1;
                    if (w_byteDone) begin
                        case (r_state)
                            CMD: begin
                                r_opcode  <= w_byte;
                                r_progAcc <= (w_byte == OpProgram) && r_wel && w_wpN;
                            end
                            ADDR: begin
                                r_addr    <= MemAddrW'({r_addr, w_byte});
                                r_addrCnt <= r_addrCnt + 2'd1;
                            end
                            DATA: if (r_opcode == OpProgram) r_addr <= w_pageNext;
                            default: ;
                        endcase
                    end
                end
                // A zero bit count on a falling edge marks the boundary where the next tx byte loads.
                if (w_sckFall) begin
                    if (r_bitCnt == 3'd0) begin
                        r_cipo    <= w_txByte[7];
                        r_txShift <= {w_txByte[6:0], 1'b0};
                        if (r_state == DATA && r_opcode == OpJedec)
                            r_idIdx <= (r_idIdx == 2'd2) ? 2'd0 : r_idIdx + 2'd1;
                        if (r_state == DATA && r_opcode == OpRead)
                            r_addr <= r_addr + MemAddrW'(1);
                    end else begin
                        r_cipo    <= r_txShift[7];
                        r_txShift <= {r_txShift[6:0], 1'b0};
                    end
                end
            end
            if (w_csRise) begin
                if (r_opcode == OpWren && r_bitTotal == 4'd8)      r_wel <= 1'b1;
                else if (r_opcode == OpWrdi && r_bitTotal == 4'd8) r_wel <= 1'b0;
                else if (r_progAcc || w_erase)                     r_wel <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_erase) begin
            r_valid <= '0;
        end else if (w_memWe) begin
            r_valid[r_addr] <= 1'b1;
            r_mem[r_addr]   <= w_byte;
        end
    end
endmodule

// File: tb/tb_spi_dpi_flash.sv
// Directed bench for spi_dpi_flash: drives SPI transactions and scores returned bytes against a queue.
module tb_spi_dpi_flash;
    localparam int Half = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    int         compared = 0;
    int         mismatched = 0;
    logic [7:0] expQ[$];
    string      tagQ[$];

    spi_dpi_flash_if #(.NDevices(1), .DataW(1), .OOB_InW(2), .OOB_OutW(1)) bus ();

    spi_dpi_flash #(
        .NDevices(1), .DataW(1), .OOB_InW(2), .OOB_OutW(1), .MemAddrW(8), .JedecId(24'hEF4016)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkValue(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input logic [7:0] observed);
        if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL scoreboard: observed %h with no expected entry", observed);
        end else begin
            checkValue(tagQ.pop_front(), observed, expQ.pop_front());
        end
    endtask

    task automatic spiXfer(input logic [7:0] tx, input int nBits, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i >= 8 - nBits; i--) begin
            bus.copi = tx[i];
            waitClk(Half);
            rx[i] = bus.cipo;
            bus.sck = 1'b1;
            waitClk(Half);
            bus.sck = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] tx, input string tag, input logic [7:0] expected);
        logic [7:0] rx;
        expQ.push_back(expected);
        tagQ.push_back(tag);
        spiXfer(tx, 8, rx);
        checkOutput(rx);
    endtask

    task automatic quiet(input logic [7:0] tx);
        applyStimulus(tx, "quietCipo", 8'h00);
    endtask

    task automatic csBegin();
        bus.cs = '0;
        waitClk(Half);
    endtask

    task automatic csEnd();
        waitClk(Half);
        bus.cs = '1;
        waitClk(2 * Half);
    endtask

    task automatic simpleCmd(input logic [7:0] op);
        csBegin();
        quiet(op);
        csEnd();
    endtask

    task automatic readStatus(input string tag, input logic [7:0] expected);
        csBegin();
        quiet(8'h05);
        applyStimulus(8'h00, tag, expected);
        csEnd();
    endtask

    task automatic startAddrCmd(input logic [7:0] op, input logic [23:0] addr);
        csBegin();
        quiet(op);
        quiet(addr[23:16]);
        quiet(addr[15:8]);
        quiet(addr[7:0]);
    endtask

    initial begin
        logic [7:0] rx;
        rst_n      = 1'b0;
        bus.sck    = 1'b0;
        bus.cs     = '1;
        bus.copi   = '0;
        bus.oob_in = 2'b11;
        waitClk(4);
        checkValue("resetCipo", 8'(bus.cipo), 8'h00);
        checkValue("resetOob", 8'(bus.oob_out), 8'h00);
        rst_n = 1'b1;
        waitClk(4);

        csBegin();
        quiet(8'h9F);
        applyStimulus(8'h00, "id0", 8'hEF);
        applyStimulus(8'h00, "id1", 8'h40);
        applyStimulus(8'h00, "id2", 8'h16);
        applyStimulus(8'h00, "id3", 8'hEF);
        applyStimulus(8'h00, "id4", 8'h40);
        applyStimulus(8'h00, "id5", 8'h16);
        csEnd();

        simpleCmd(8'h06);
        readStatus("statusWren", 8'h02);
        checkValue("oobWel", 8'(bus.oob_out), 8'h01);
        simpleCmd(8'h04);
        readStatus("statusWrdi", 8'h00);
        checkValue("oobWrdi", 8'(bus.oob_out), 8'h00);

        simpleCmd(8'h06);
        startAddrCmd(8'h02, 24'h000010);
        quiet(8'hA5);
        quiet(8'h5A);
        csEnd();
        startAddrCmd(8'h03, 24'h000010);
        applyStimulus(8'h00, "read10", 8'hA5);
        applyStimulus(8'h00, "read11", 8'h5A);
        applyStimulus(8'h00, "read12", 8'hFF);
        csEnd();
        readStatus("welAfterProg", 8'h00);

        startAddrCmd(8'h02, 24'h000020);
        quiet(8'h33);
        csEnd();
        startAddrCmd(8'h03, 24'h000020);
        applyStimulus(8'h00, "noWelRead", 8'hFF);
        csEnd();
        simpleCmd(8'h06);
        bus.oob_in = 2'b10;
        waitClk(4);
        startAddrCmd(8'h02, 24'h000020);
        quiet(8'h33);
        csEnd();
        bus.oob_in = 2'b11;
        waitClk(4);
        startAddrCmd(8'h03, 24'h000020);
        applyStimulus(8'h00, "wpRead", 8'hFF);
        csEnd();
        readStatus("welAfterWp", 8'h02);

        startAddrCmd(8'h02, 24'h0000FF);
        quiet(8'h11);
        quiet(8'h22);
        csEnd();
        startAddrCmd(8'h03, 24'h0000FF);
        applyStimulus(8'h00, "readFF", 8'h11);
        applyStimulus(8'h00, "read00", 8'h22);
        applyStimulus(8'h00, "read01", 8'hFF);
        csEnd();

        csBegin();
        quiet(8'h06);
        spiXfer(8'h00, 1, rx);
        checkValue("wrenExtraBit", rx, 8'h00);
        csEnd();
        readStatus("welNineBits", 8'h00);

        simpleCmd(8'h06);
        simpleCmd(8'hC7);
        readStatus("welAfterErase", 8'h00);
        startAddrCmd(8'h03, 24'h000010);
        applyStimulus(8'h00, "erased10", 8'hFF);
        csEnd();
        startAddrCmd(8'h03, 24'h000000);
        applyStimulus(8'h00, "erased00", 8'hFF);
        csEnd();

        simpleCmd(8'h06);
        startAddrCmd(8'h03, 24'h000010);
        waitClk(Half);
        checkValue("preResetCipo", 8'(bus.cipo), 8'h01);
        checkValue("preResetOob", 8'(bus.oob_out), 8'h01);
        rst_n = 1'b0;
        #1;
        checkValue("midResetCipo", 8'(bus.cipo), 8'h00);
        checkValue("midResetOob", 8'(bus.oob_out), 8'h00);
        bus.cs = '1;
        waitClk(4);
        rst_n = 1'b1;
        waitClk(4);
        csBegin();
        quiet(8'h9F);
        applyStimulus(8'h00, "postId0", 8'hEF);
        applyStimulus(8'h00, "postId1", 8'h40);
        applyStimulus(8'h00, "postId2", 8'h16);
        csEnd();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
